// File: rtl/rtx_pixel_stacker_if.sv
// Pixel-in / DRAM-word-out bundle for rtx_pixel_stacker.
// The slave side is the stacker itself; the master side is the pixel producer plus the word consumer.
interface rtx_pixel_stacker_if;
    logic         pix_valid;
    logic [15:0]  pix_data;
    logic [10:0]  pix_h;
    logic [9:0]   pix_v;
    logic         word_valid;
    logic         word_ready;
    logic [127:0] word_data;
    logic [7:0]   word_strb;
    logic [16:0]  word_addr;
    logic         overflow;
    logic [15:0]  drop_count;

    modport slave (
        input  pix_valid, pix_data, pix_h, pix_v, word_ready,
        output word_valid, word_data, word_strb, word_addr, overflow, drop_count
    );

    modport master (
        output pix_valid, pix_data, pix_h, pix_v, word_ready,
        input  word_valid, word_data, word_strb, word_addr, overflow, drop_count
    );
endinterface

// File: rtl/rtx_pixel_stacker.sv
// Packs raster-order RGB565 pixels into 8-pixel strobed DRAM words and queues them in a small FWFT FIFO.
// Pipeline: input register -> word assembler -> commit register -> FIFO.
module rtx_pixel_stacker #(
    parameter int H_RES      = 1280,
    parameter int V_RES      = 720,
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    rtx_pixel_stacker_if.slave   bus
);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int IDLE_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {EMPTY, FILLING, FLUSH} state_t;
    typedef logic [152:0] entry_t;

    logic [20:0]  lin_addr;
    logic         in_range;
    logic         in_valid;
    logic [15:0]  in_data;
    logic [2:0]   in_lane;
    logic [16:0]  in_addr;

    assign lin_addr = 21'(bus.pix_v) * 21'(H_RES) + 21'(bus.pix_h);
    assign in_range = (32'(bus.pix_h) < H_RES) && (32'(bus.pix_v) < V_RES);

    always_ff @(posedge clk) begin
        if (!rst) begin
            in_valid <= 1'b0;
            in_data  <= '0;
            in_lane  <= '0;
            in_addr  <= '0;
        end else begin
            in_valid <= bus.pix_valid && in_range;
            in_data  <= bus.pix_data;
            in_lane  <= bus.pix_h[2:0];
            in_addr  <= 17'(lin_addr >> 3);
        end
    end

    state_t              state, state_n;
    logic [127:0]        cur_data, cur_data_n, new_data, merged_data;
    logic [7:0]          cur_strb, cur_strb_n, new_strb, merged_strb;
    logic [16:0]         cur_addr, cur_addr_n;
    logic [IDLE_W-1:0]   idle_cnt, idle_n;
    logic                cm_valid, cm_valid_n;
    logic [127:0]        cm_data, cm_data_n;
    logic [7:0]          cm_strb, cm_strb_n;
    logic [16:0]         cm_addr, cm_addr_n;

    assign new_data    = 128'(in_data) << {in_lane, 4'b0000};
    assign new_strb    = 8'b1 << in_lane;
    assign merged_data = (cur_data & ~(128'(16'hFFFF) << {in_lane, 4'b0000})) | new_data;
    assign merged_strb = cur_strb | new_strb;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= EMPTY;
            cur_data <= '0;
            cur_strb <= '0;
            cur_addr <= '0;
            idle_cnt <= '0;
            cm_valid <= 1'b0;
            cm_data  <= '0;
            cm_strb  <= '0;
            cm_addr  <= '0;
        end else begin
            state    <= state_n;
            cur_data <= cur_data_n;
            cur_strb <= cur_strb_n;
            cur_addr <= cur_addr_n;
            idle_cnt <= idle_n;
            cm_valid <= cm_valid_n;
            cm_data  <= cm_data_n;
            cm_strb  <= cm_strb_n;
            cm_addr  <= cm_addr_n;
        end
    end

    // FLUSH holds a complete lane-7 word that arrived on a discontinuity, so only one word commits per cycle.
    always_comb begin
        state_n    = state;
        cur_data_n = cur_data;
        cur_strb_n = cur_strb;
        cur_addr_n = cur_addr;
        idle_n     = idle_cnt;
        cm_valid_n = 1'b0;
        cm_data_n  = cur_data;
        cm_strb_n  = cur_strb;
        cm_addr_n  = cur_addr;
        case (state)
            EMPTY: begin
                if (in_valid) begin
                    idle_n = '0;
                    if (in_lane == 3'd7) begin
                        cm_valid_n = 1'b1;
                        cm_data_n  = new_data;
                        cm_strb_n  = new_strb;
                        cm_addr_n  = in_addr;
                    end else begin
                        cur_data_n = new_data;
                        cur_strb_n = new_strb;
                        cur_addr_n = in_addr;
                        state_n    = FILLING;
                    end
                end
            end
            FILLING: begin
                if (in_valid && in_addr == cur_addr) begin
                    idle_n = '0;
                    if (in_lane == 3'd7) begin
                        cm_valid_n = 1'b1;
                        cm_data_n  = merged_data;
                        cm_strb_n  = merged_strb;
                        state_n    = EMPTY;
                    end else begin
                        cur_data_n = merged_data;
                        cur_strb_n = merged_strb;
                    end
                end else if (in_valid) begin
                    idle_n     = '0;
                    cm_valid_n = 1'b1;
                    cur_data_n = new_data;
                    cur_strb_n = new_strb;
                    cur_addr_n = in_addr;
                    state_n    = (in_lane == 3'd7) ? FLUSH : FILLING;
                end else if (idle_cnt == IDLE_W'(TIMEOUT - 1)) begin
                    idle_n     = '0;
                    cm_valid_n = 1'b1;
                    state_n    = EMPTY;
                end else begin
                    idle_n = idle_cnt + IDLE_W'(1);
                end
            end
            FLUSH: begin
                cm_valid_n = 1'b1;
                idle_n     = '0;
                state_n    = EMPTY;
                if (in_valid) begin
                    cur_data_n = new_data;
                    cur_strb_n = new_strb;
                    cur_addr_n = in_addr;
                    state_n    = (in_lane == 3'd7) ? FLUSH : FILLING;
                end
            end
            default: state_n = EMPTY;
        endcase
    end

    entry_t            mem [FIFO_DEPTH];
    entry_t            head;
    logic [PTR_W:0]    wr_ptr, rd_ptr;
    logic              empty, full, push, pop, drop;
    logic              overflow_r;
    logic [15:0]       drop_cnt_r;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                   (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign pop   = !empty && bus.word_ready;
    assign push  = cm_valid && (!full || pop);
    assign drop  = cm_valid && full && !pop;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[PTR_W-1:0]] <= {cm_data, cm_strb, cm_addr};
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            overflow_r <= 1'b0;
            drop_cnt_r <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (drop) begin
                overflow_r <= 1'b1;
                if (drop_cnt_r != 16'hFFFF) drop_cnt_r <= drop_cnt_r + 16'd1;
            end
        end
    end

    // Gate the head so the bus reads all-zero whenever the FIFO is empty, including straight after reset.
    assign head           = empty ? '0 : mem[rd_ptr[PTR_W-1:0]];
    assign bus.word_valid = !empty;
    assign bus.word_data  = head[152:25];
    assign bus.word_strb  = head[24:17];
    assign bus.word_addr  = head[16:0];
    assign bus.overflow   = overflow_r;
    assign bus.drop_count = drop_cnt_r;
endmodule

// File: doc/rtx_pixel_stacker.md
Name: rtx_pixel_stacker

Overview:
- Sits between the rtx core's pixel output (rtx_pixel/pixel_h/pixel_v/ray_done) and the DRAM frame-buffer write path, all in the rtx clock domain.
- Coalesces raster-order 16-bit RGB565 pixels into 128-bit, 8-pixel DRAM words with a per-pixel write strobe and a word address.
- Buffers finished words in a small FIFO with valid/ready, so short DRAM-side stalls do not lose pixels.
- Counts any word dropped on overflow.

Parameters:
- H_RES, 1280, pixels per line; must be a multiple of 8.
- V_RES, 720, lines per frame.
- FIFO_DEPTH, 4, output word FIFO entries; power of 2, at least 2.
- TIMEOUT, 64, idle cycles after which a partially filled word is flushed.

Ports:
- clk  in  1  rtx clock.
- rst  in  1  synchronous, active-low reset (0 = reset).
- pix_valid  in  1  one-cycle pixel strobe (rtx ray_done).
- pix_data  in  16  RGB565 pixel.
- pix_h  in  11  pixel column.
- pix_v  in  10  pixel row.
- word_valid  out  1  head FIFO word valid.
- word_ready  in  1  consumer accepts head word.
- word_data  out  128  8 pixels; lane k occupies bits [16k+15:16k].
- word_strb  out  8  lane k written when bit k is 1.
- word_addr  out  17  word index = (pix_v*H_RES + pix_h) >> 3.
- overflow  out  1  sticky; set on any dropped word.
- drop_count  out  16  saturating count of dropped words.

Behaviour:
- Reset (rst==0 at a clk edge):
  - All outputs 0.
  - Assembler empty; FIFO empty; overflow and drop_count cleared.
  - Any partial word is discarded, not flushed.
- Address and lane:
  - lane = pix_h[2:0].
  - waddr = pix_v*H_RES + pix_h, then >>3; use a 21-bit intermediate, truncate to 17 bits.
  - Pixels with pix_h>=H_RES or pix_v>=V_RES are ignored entirely and do not reset the idle timer.
- Assembler state: EMPTY / FILLING, plus cur_addr, cur_data, cur_strb, idle_cnt.
- EMPTY + valid pixel:
  - Load cur_addr=waddr, cur_strb = 1<<lane, data into its lane.
  - Go to FILLING.
  - If lane==7, commit immediately and stay EMPTY.
- FILLING + valid pixel with waddr==cur_addr:
  - Write the lane and set its strobe bit; a rewritten lane takes the new value.
  - If lane==7, commit and go to EMPTY.
- FILLING + valid pixel with waddr!=cur_addr (discontinuity):
  - Commit the current word.
  - Start a new word from this pixel in the same cycle; lane==7 in the new word is not allowed to double-commit.
  - The new pixel is held one extra cycle (1-entry skid) and committed next cycle if lane==7.
- Timeout: in FILLING with no accepted pixel for TIMEOUT consecutive cycles, commit the partial word and go to EMPTY.
  - idle_cnt resets on every accepted pixel.
- Commit: push {cur_data, cur_strb, cur_addr} into the FIFO on the next clk edge.
  - If the FIFO is full and no pop occurs that same cycle, drop the word.
  - On drop: set overflow, increment drop_count (saturating at 16'hFFFF).
  - A pop and a push in the same cycle when full both succeed.
- FIFO:
  - First-word-fall-through; word_valid = !empty.
  - Pop when word_valid && word_ready.
  - word_* outputs are stable while word_valid && !word_ready.
- Latency: lane-7 pixel accepted at edge N → word_valid high after edge N+2 when the FIFO was empty and no stall. Minimum 1 word per cycle throughput.
- Unwritten lanes have word_data 0 and their strobe bit 0.
- Frame wrap (h=H_RES-1, v=V_RES-1 followed by 0,0) is just a discontinuity; no special handling.

Test Plan:
- Pixels h=0..7, v=0, data=16'h1000+h, on consecutive cycles:
  - one word with addr 0, strb 8'hFF, lane k = 16'h100k.
  - word_valid rises 2 cycles after the h=7 pixel.
- Pixels h=8..10, v=1, then idle 64 cycles:
  - partial flush with addr 161 and strb 8'h07.
- Pixel h=3 v=0, then h=20 v=0:
  - first word flushes with addr 0, strb 8'h08.
  - a new word starts at addr 2, lane 4.
- Hold word_ready=0 and stream 48 sequential pixels (6 words):
  - the first 4 words are kept, 2 are dropped.
  - overflow=1 and drop_count=2; draining returns addrs 0..3 in order.
- Pixel with h=1280:
  - ignored; no word produced and the timer is unaffected.
- Assert rst=0 mid-word (strb 8'h0F):
  - no word emitted; all outputs 0 the next cycle.
  - the next 8 pixels form a clean word.
